// File: rtl/mac_frame_loader_pkg.sv
// mac_frame_loader_pkg
//  Shared constants for the cat-recogniser pixel loader. Holds the image
//  geometry defaults that the loader and its bus interface are built around
//  and the loader FSM state codes.
package mac_frame_loader_pkg;

  // Image geometry defaults (64x64 RGB image, 8-bit samples).
  localparam int NUMBER_OF_PIXELS = 12288;
  localparam int PIXEL_PRECISION  = 8;

  // Loader FSM state type and codes.
  typedef logic [1:0] loader_st_t;

  localparam logic [1:0] LOADER_ST_FILL    = 2'd0;
  localparam logic [1:0] LOADER_ST_RUN     = 2'd1;
  localparam logic [1:0] LOADER_ST_SETTLE  = 2'd2;
  localparam logic [1:0] LOADER_ST_CAPTURE = 2'd3;

endpackage

// File: rtl/mac_frame_loader_if.sv
// mac_frame_loader_if
//  Bundles the pixel stream, the MAC-facing signals and the decision outputs
//  of mac_frame_loader.
//  slave  : loader side (consumes pixels and MAC status, drives PixData,
//           startWork, pix_ready and the result/error pulses)
//  master : environment side (pixel source plus SlowMAC_Unit)
interface mac_frame_loader_if #(
  parameter int NUM_PIX = mac_frame_loader_pkg::NUMBER_OF_PIXELS,
  parameter int PIX_W   = mac_frame_loader_pkg::PIXEL_PRECISION
);

  logic                     pix_valid;
  logic [PIX_W-1:0]         pix_data;
  logic                     pix_last;
  logic                     pix_ready;
  logic [NUM_PIX*PIX_W-1:0] PixData;
  logic                     startWork;
  logic                     pDone;
  logic                     SigmoidZ;
  logic                     cat_valid;
  logic                     cat_out;
  logic                     frame_err;
  logic                     mac_err;

  modport slave (
    input  pix_valid, pix_data, pix_last, pDone, SigmoidZ,
    output pix_ready, PixData, startWork, cat_valid, cat_out, frame_err, mac_err
  );

  modport master (
    output pix_valid, pix_data, pix_last, pDone, SigmoidZ,
    input  pix_ready, PixData, startWork, cat_valid, cat_out, frame_err, mac_err
  );

endinterface

// File: rtl/mac_frame_loader.sv
// mac_frame_loader
//  Upstream feeder for the single-neuron SlowMAC_Unit. Collects one image as
//  a serial valid/ready pixel stream into the flat PixData bus, holds
//  startWork high for exactly one MAC pass (NUM_PIX+1 cycles), waits one
//  settle cycle for the MAC to latch its result, then captures SigmoidZ as
//  the cat/not-cat decision.
// Ports
//  Clk        clock, all state on posedge
//  Rst        asynchronous reset, active low
//  bus.slave  pix_valid/pix_data/pix_last/pix_ready pixel stream,
//             PixData/startWork/pDone/SigmoidZ MAC link,
//             cat_valid/cat_out decision, frame_err/mac_err error pulses
module mac_frame_loader
  import mac_frame_loader_pkg::*;
#(
  parameter int NUM_PIX = NUMBER_OF_PIXELS,
  parameter int PIX_W   = PIXEL_PRECISION
) (
  input logic              Clk,
  input logic              Rst,
  mac_frame_loader_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_PIX + 2);
  localparam int IDX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);
  localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(NUM_PIX);

  loader_st_t       state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             start_q, start_d;
  logic             cat_valid_q, cat_valid_d;
  logic             cat_q, cat_d;
  logic             frame_err_q, frame_err_d;
  logic             mac_err_q, mac_err_d;
  logic             wr_en;
  logic             accept;

  logic [NUM_PIX-1:0][PIX_W-1:0] pix_q;

  assign bus.pix_ready = (state_q == LOADER_ST_FILL);
  assign accept        = bus.pix_valid && (state_q == LOADER_ST_FILL);

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    run_cnt_d   = run_cnt_q;
    start_d     = start_q;
    cat_d       = cat_q;
    cat_valid_d = 1'b0;
    frame_err_d = 1'b0;
    mac_err_d   = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      LOADER_ST_FILL: begin
        if (accept) begin
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d = '0;
            if (bus.pix_last) begin
              wr_en   = 1'b1;
              start_d = 1'b1;
              state_d = LOADER_ST_RUN;
            end else begin
              // Image overran its length: drop this beat and resync.
              frame_err_d = 1'b1;
            end
          end else begin
            wr_en = 1'b1;
            if (bus.pix_last) begin
              // Short image: restart counting; stale slots get overwritten
              // by the next complete image.
              frame_err_d = 1'b1;
              pix_cnt_d   = '0;
            end else begin
              pix_cnt_d = pix_cnt_q + 1'b1;
            end
          end
        end
      end

      LOADER_ST_RUN: begin
        // MAC walks its own counter 0..NUM_PIX, so it needs NUM_PIX+1
        // enabled cycles.
        if (run_cnt_q == LAST_RUN) begin
          run_cnt_d = '0;
          start_d   = 1'b0;
          state_d   = LOADER_ST_SETTLE;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end

      LOADER_ST_SETTLE: begin
        // MAC latches SigmoidZ on this edge; sample it one cycle later.
        state_d = LOADER_ST_CAPTURE;
      end

      LOADER_ST_CAPTURE: begin
        cat_d       = bus.SigmoidZ;
        cat_valid_d = 1'b1;
        mac_err_d   = ~bus.pDone;
        state_d     = LOADER_ST_FILL;
      end

      default: begin
        state_d = LOADER_ST_FILL;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= LOADER_ST_FILL;
      pix_cnt_q   <= '0;
      run_cnt_q   <= '0;
      start_q     <= 1'b0;
      cat_q       <= 1'b0;
      cat_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      mac_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      run_cnt_q   <= run_cnt_d;
      start_q     <= start_d;
      cat_q       <= cat_d;
      cat_valid_q <= cat_valid_d;
      frame_err_q <= frame_err_d;
      mac_err_q   <= mac_err_d;
    end
  end

  // Image store; pix_cnt never exceeds NUM_PIX-1 while writing.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pix_q <= '0;
    end else if (wr_en) begin
      pix_q[pix_cnt_q[IDX_W-1:0]] <= bus.pix_data;
    end
  end

  assign bus.PixData   = pix_q;
  assign bus.startWork = start_q;
  assign bus.cat_valid = cat_valid_q;
  assign bus.cat_out   = cat_q;
  assign bus.frame_err = frame_err_q;
  assign bus.mac_err   = mac_err_q;

endmodule

// File: tb/tb_mac_frame_loader.sv
module tb_mac_frame_loader;

  localparam int N = 4;
  localparam int W = 8;

  logic Clk;
  logic Rst;

  mac_frame_loader_if #(.NUM_PIX(N), .PIX_W(W)) bus ();

  mac_frame_loader #(.NUM_PIX(N), .PIX_W(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  // Environment knobs for the MAC stand-in.
  int bias     = 0;
  bit mac_fail = 0;

  // Neuron with all weights +1: fires when pixel sum plus bias is positive.
  function automatic bit decide(input logic [31:0] p, input int b);
    int s;
    s = int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16]) + int'(p[31:24]);
    return (s + b) > 0;
  endfunction

  // SlowMAC_Unit stand-in: counts enabled cycles; once a full pass of N+1
  // cycles is followed by startWork low, it raises pDone and presents the
  // decision.
  int mcnt;
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mcnt         <= 0;
      bus.pDone    <= 1'b0;
      bus.SigmoidZ <= 1'b0;
    end else if (bus.startWork) begin
      mcnt      <= mcnt + 1;
      bus.pDone <= 1'b0;
    end else if (mcnt == N + 1) begin
      mcnt         <= 0;
      bus.pDone    <= !mac_fail;
      bus.SigmoidZ <= decide(bus.PixData, bias);
    end else begin
      mcnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge
  // with pix_valid dropped.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int n;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_last  = last;
    n = 0;
    while (!bus.pix_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] p);
    for (int i = 0; i < N; i++) send_beat(p[8*i +: 8], i == N - 1);
  endtask

  task automatic wait_cat(input string name);
    int n;
    n = 0;
    while (!bus.cat_valid && n < 30) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 30) chk({name, "_cat_timeout"}, 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [7:0]  p0, p1, p2, p3;
    int          b;
    logic [31:0] exp_pix;
    logic        exp_cat;
  } vec_t;

  vec_t vecs[7];

  typedef struct packed {
    logic [31:0] pix;
    logic        cat;
    logic        merr;
  } obs_t;

  obs_t        obs_q[$];
  logic [31:0] exp_pix_q[$];
  bit          exp_cat_q[$];
  int          obs_err = 0;
  bit          mon_en  = 0;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (bus.cat_valid) obs_q.push_back({bus.PixData, bus.cat_out, bus.mac_err});
      if (bus.frame_err) obs_err <= obs_err + 1;
    end
  end

  initial begin
    logic [7:0] q[$];
    int exp_err;
    int len;
    logic [7:0] d;
    logic last;

    vecs[0] = '{8'd10,  8'd20, 8'd30,  8'd40, 0,    32'h281E140A, 1'b1};
    vecs[1] = '{8'd10,  8'd20, 8'd30,  8'd40, -200, 32'h281E140A, 1'b0};
    vecs[2] = '{8'd10,  8'd20, 8'd30,  8'd40, 0,    32'h281E140A, 1'b1};
    vecs[3] = '{8'd1,   8'd2,  8'd3,   8'd4,  -10,  32'h04030201, 1'b0};
    vecs[4] = '{8'd1,   8'd2,  8'd3,   8'd4,  -9,   32'h04030201, 1'b1};
    vecs[5] = '{8'd255, 8'd0,  8'd128, 8'd1,  -300, 32'h018000FF, 1'b1};
    vecs[6] = '{8'd0,   8'd0,  8'd0,   8'd0,  0,    32'h00000000, 1'b0};

    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_last  = 1'b0;
    Rst = 1'b0;
    repeat (3) @(negedge Clk);

    chk("rst_pix_ready", bus.pix_ready, 1);
    chk("rst_startWork", bus.startWork, 0);
    chk("rst_PixData",   bus.PixData,   0);
    chk("rst_cat_out",   bus.cat_out,   0);
    chk("rst_cat_valid", bus.cat_valid, 0);
    Rst = 1'b1;
    @(negedge Clk);

    // Basic image with cycle-exact timing.
    bias = 0;
    for (int i = 0; i < N - 1; i++) send_beat(8'(10 * (i + 1)), 1'b0);
    send_beat(8'd40, 1'b1);
    chk("t2_PixData", bus.PixData, 32'h281E140A);
    for (int k = 0; k <= 7; k++) begin
      chk($sformatf("t2_startWork_%0d", k), bus.startWork, (k <= 4));
      chk($sformatf("t2_cat_valid_%0d", k), bus.cat_valid, (k == 7));
      chk($sformatf("t2_pix_ready_%0d", k), bus.pix_ready, (k == 7));
      if (k < 7) @(negedge Clk);
    end
    chk("t2_cat_out", bus.cat_out, 1);
    chk("t2_mac_err", bus.mac_err, 0);
    @(negedge Clk);
    chk("t2_cat_pulse", bus.cat_valid, 0);
    chk("t2_cat_held",  bus.cat_out,   1);

    // Asynchronous reset mid-sim with non-zero state.
    Rst = 1'b0;
    #1;
    chk("t1_PixData",   bus.PixData,   0);
    chk("t1_cat_out",   bus.cat_out,   0);
    chk("t1_startWork", bus.startWork, 0);
    chk("t1_pix_ready", bus.pix_ready, 1);
    chk("t1_errs",      {bus.frame_err, bus.mac_err, bus.cat_valid}, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Table of complete images.
    foreach (vecs[i]) begin
      bias = vecs[i].b;
      send_frame({vecs[i].p3, vecs[i].p2, vecs[i].p1, vecs[i].p0});
      wait_cat($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_cat", i), bus.cat_out, vecs[i].exp_cat);
      chk($sformatf("vec%0d_pix", i), bus.PixData, vecs[i].exp_pix);
      chk($sformatf("vec%0d_merr", i), bus.mac_err, 0);
    end
    bias = 0;

    // Short image then a good one.
    send_beat(8'd1, 1'b0);
    send_beat(8'd2, 1'b1);
    chk("t4_frame_err", bus.frame_err, 1);
    @(negedge Clk);
    chk("t4_err_pulse", bus.frame_err, 0);
    repeat (2) @(negedge Clk);
    chk("t4_no_start", bus.startWork, 0);
    send_frame(32'h281E140A);
    wait_cat("t4");
    chk("t4_cat", bus.cat_out, 1);

    // Overlong image: 4th beat without last is dropped.
    for (int i = 0; i < N; i++) send_beat(8'(5 + i), 1'b0);
    chk("t5_frame_err", bus.frame_err, 1);
    chk("t5_ready",     bus.pix_ready, 1);
    send_frame(32'h281E140A);
    chk("t5_pix_after_drop", bus.PixData, 32'h281E140A);
    // Source holds a beat through the pass; nothing consumed until FILL.
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'hEE;
    bus.pix_last  = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      chk($sformatf("t5_hold_ready_%0d", k), bus.pix_ready, (k == 7));
      chk($sformatf("t5_hold_pix_%0d", k), bus.PixData, 32'h281E140A);
      if (k < 7) @(negedge Clk);
    end
    chk("t5_hold_cat", bus.cat_out, 1);
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    chk("t5_held_taken", bus.PixData, 32'h281E14EE);
    send_beat(8'd20, 1'b0);
    send_beat(8'd30, 1'b0);
    send_beat(8'd40, 1'b1);
    wait_cat("t5");
    chk("t5_cat", bus.cat_out, 1);
    chk("t5_pix", bus.PixData, 32'h281E14EE);

    // MAC not done at capture.
    mac_fail = 1;
    send_frame(32'h281E140A);
    wait_cat("merr");
    chk("merr_flag", bus.mac_err, 1);
    chk("merr_cat",  bus.cat_out, 1);
    mac_fail = 0;
    @(negedge Clk);

    // Reset in the middle of a pass.
    send_frame(32'h04030201);
    repeat (2) @(negedge Clk);
    chk("t6_running", bus.startWork, 1);
    Rst = 1'b0;
    #1;
    chk("t6_startWork", bus.startWork, 0);
    chk("t6_ready",     bus.pix_ready, 1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    bias = -10;
    send_frame(32'h0A0B0C0D);
    wait_cat("t6");
    chk("t6_cat",  bus.cat_out, 1);
    chk("t6_merr", bus.mac_err, 0);
    bias = 0;
    @(negedge Clk);

    // Randomised traffic against the frame-level model.
    bias    = -500;
    exp_err = 0;
    mon_en  = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge Clk);
        d    = 8'($urandom);
        last = (j == len - 1) && ($urandom_range(0, 3) != 0);
        send_beat(d, last);
        if (q.size() == N - 1 && !last) begin
          exp_err++;
          q.delete();
        end else begin
          q.push_back(d);
          if (last) begin
            if (q.size() == N) begin
              exp_pix_q.push_back({q[3], q[2], q[1], q[0]});
              exp_cat_q.push_back(decide({q[3], q[2], q[1], q[0]}, bias));
            end else begin
              exp_err++;
            end
            q.delete();
          end
        end
      end
    end
    repeat (20) @(negedge Clk);
    mon_en = 0;
    chk("rand_frames", obs_q.size(), exp_pix_q.size());
    chk("rand_errs",   obs_err,      exp_err);
    for (int i = 0; i < obs_q.size() && i < exp_pix_q.size(); i++) begin
      chk($sformatf("rand%0d_pix", i),  obs_q[i].pix,  exp_pix_q[i]);
      chk($sformatf("rand%0d_cat", i),  obs_q[i].cat,  exp_cat_q[i]);
      chk($sformatf("rand%0d_merr", i), obs_q[i].merr, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
